// File: rtl/common_pkg.sv
// Shared types and widths for the RV32 core pipeline.
// Holds the EX-stage control bundle and the EX/MEM hand-off payload.
package common_pkg;

  localparam int RISC_V_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH    = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_ne;
  } ex_ctrl_t;

  typedef struct packed {
    logic [RISC_V_DATA_WIDTH-1:0] alu_result;
    logic [RISC_V_DATA_WIDTH-1:0] rs2_data;
    logic [REG_ADDR_WIDTH-1:0]    rd_addr;
    logic                         reg_write;
    logic                         mem_read;
    logic                         mem_write;
    logic                         branch_taken;
    logic [RISC_V_DATA_WIDTH-1:0] branch_target;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM stage register: an output slot backed by a one-entry skid slot, so
// upstream sees a purely registered ready and no beat is lost on back-pressure.
module ex_mem_reg
  import common_pkg::*;
#(
  parameter int DATA_WIDTH     = RISC_V_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = common_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_zero,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [DATA_WIDTH-1:0]     pc,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  ex_ctrl_t                  ctrl,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output ex_mem_payload_t           mem_payload
);

  ex_mem_payload_t       in_pld;
  ex_mem_payload_t       skid_pld_p0;
  ex_mem_payload_t       out_pld_p1;
  logic                  skid_vld_p0;
  logic                  vld_p1;
  logic                  in_xfer;
  logic                  out_free;
  logic                  load_skid;
  logic                  load_out_skid;
  logic                  load_out_in;
  logic [DATA_WIDTH-1:0] target;

  // Capture: resolve the branch and form the payload from the ALU outputs.
  always_comb begin
    target                  = pc + imm;
    in_pld                  = '0;
    in_pld.alu_result       = alu_result;
    in_pld.rs2_data         = rs2_data;
    in_pld.rd_addr          = rd_addr;
    in_pld.reg_write        = ctrl.reg_write;
    in_pld.mem_read         = ctrl.mem_read;
    in_pld.mem_write        = ctrl.mem_write;
    in_pld.branch_taken     = ctrl.branch & (alu_zero ^ ctrl.branch_ne);
    in_pld.branch_target    = target;
  end

  // ready depends only on the skid register, never on mem_ready.
  assign ex_ready = !skid_vld_p0;
  assign in_xfer  = ex_valid && ex_ready;
  assign out_free = !vld_p1 || mem_ready;

  // Skid drains first; a new beat only bypasses to out when skid is empty.
  assign load_out_skid = out_free && skid_vld_p0;
  assign load_out_in   = out_free && !skid_vld_p0 && in_xfer;
  assign load_skid     = in_xfer && (!out_free || skid_vld_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (out_free) begin
      vld_p1      <= skid_vld_p0 || in_xfer;
      skid_vld_p0 <= skid_vld_p0 && in_xfer;
    end else begin
      vld_p1      <= 1'b1;
      skid_vld_p0 <= skid_vld_p0 || in_xfer;
    end
  end

  // Skid slot: written only while empty, so a held beat is never clobbered.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_pld_p0 <= '0;
    end else if (!flush && load_skid) begin
      skid_pld_p0 <= in_pld;
    end
  end

  // Output slot: changes only when empty or being consumed, keeping the
  // payload stable while mem_valid is high and mem_ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pld_p1 <= '0;
    end else if (!flush && load_out_skid) begin
      out_pld_p1 <= skid_pld_p0;
    end else if (!flush && load_out_in) begin
      out_pld_p1 <= in_pld;
    end
  end

  assign mem_valid   = vld_p1;
  assign mem_payload = out_pld_p1;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg with a queue-based scoreboard of accepted beats.
module tb_ex_mem_reg;
  import common_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [31:0]     alu_result;
  logic            alu_zero;
  logic [31:0]     rs2_data;
  logic [31:0]     pc;
  logic [31:0]     imm;
  logic [4:0]      rd_addr;
  ex_ctrl_t        ctrl;
  logic            mem_valid;
  logic            mem_ready;
  ex_mem_payload_t mem_payload;

  int total = 0;
  int bad   = 0;
  ex_mem_payload_t sb[$];

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .rs2_data(rs2_data), .pc(pc),
    .imm(imm), .rd_addr(rd_addr), .ctrl(ctrl), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_payload(mem_payload)
  );

  function automatic ex_mem_payload_t expect_pld();
    ex_mem_payload_t p;
    p.alu_result    = alu_result;
    p.rs2_data      = rs2_data;
    p.rd_addr       = rd_addr;
    p.reg_write     = ctrl.reg_write;
    p.mem_read      = ctrl.mem_read;
    p.mem_write     = ctrl.mem_write;
    p.branch_taken  = ctrl.branch && (alu_zero != ctrl.branch_ne);
    p.branch_target = pc + imm;
    return p;
  endfunction

  // Scoreboard: the queue holds beats accepted but not yet delivered.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      int  sz;
      bit  acc;
      sz  = sb.size();
      acc = ex_valid && (sz < 2);
      total++;
      assert (mem_valid === (sz != 0)) else begin
        bad++; $error("FAIL sb_valid got=%b exp=%b", mem_valid, sz != 0);
      end
      total++;
      assert (ex_ready === (sz < 2)) else begin
        bad++; $error("FAIL sb_ready got=%b exp=%b", ex_ready, sz < 2);
      end
      if (sz != 0) begin
        total++;
        assert (mem_payload === sb[0]) else begin
          bad++; $error("FAIL sb_payload got=%h exp=%h", mem_payload, sb[0]);
        end
        if (mem_ready) void'(sb.pop_front());
      end
      if (flush) sb.delete();
      else if (acc) sb.push_back(expect_pld());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] res, input logic zero, input logic br,
                     input logic bne, input logic [31:0] p, input logic [31:0] im);
    ex_valid   = 1'b1;
    alu_result = res;
    alu_zero   = zero;
    rs2_data   = res ^ 32'h5a5a_5a5a;
    rd_addr    = res[4:0];
    ctrl       = '{reg_write: res[0], mem_read: res[1], mem_write: res[2],
                   branch: br, branch_ne: bne};
    pc         = p;
    imm        = im;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    alu_result = '0; alu_zero = 1'b0; rs2_data = '0; pc = '0; imm = '0;
    rd_addr = '0; ctrl = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    assert (mem_valid === 1'b0 && ex_ready === 1'b1) else begin
      bad++; $error("FAIL reset_ctl got=%b%b exp=01", mem_valid, ex_ready);
    end
    total++;
    assert (mem_payload === '0) else begin
      bad++; $error("FAIL reset_pld got=%h exp=0", mem_payload);
    end
    tick();

    // Pass-through, back-to-back.
    put(32'h10, 1'b0, 1'b0, 1'b0, 32'h40, 32'h4); tick();
    put(32'h20, 1'b0, 1'b0, 1'b0, 32'h44, 32'h4); tick();
    put(32'h30, 1'b0, 1'b0, 1'b0, 32'h48, 32'h4); tick();
    ex_valid = 1'b0;
    @(negedge clk);
    total++;
    assert (mem_payload.alu_result === 32'h30 && mem_valid === 1'b1) else begin
      bad++; $error("FAIL pass_last got=%h exp=30", mem_payload.alu_result);
    end
    tick(); tick();

    // Stall: A held, B in skid, C refused until release.
    mem_ready = 1'b0;
    put(32'hA, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    put(32'hB, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    put(32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick(); tick();
    @(negedge clk);
    total++;
    assert (mem_payload.alu_result === 32'hA && ex_ready === 1'b0) else begin
      bad++; $error("FAIL stall_hold got=%h/%b exp=a/0", mem_payload.alu_result, ex_ready);
    end
    mem_ready = 1'b1;
    tick(); tick();
    ex_valid = 1'b0;
    tick(); tick(); tick();

    // Branch resolution and target wrap.
    put(32'h0, 1'b1, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFF8); tick();
    ex_valid = 1'b0;
    @(negedge clk);
    total++;
    assert (mem_payload.branch_taken === 1'b1 && mem_payload.branch_target === 32'hF8) else begin
      bad++; $error("FAIL br_beq got=%b/%h exp=1/f8", mem_payload.branch_taken, mem_payload.branch_target);
    end
    tick();
    put(32'h0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFF8); tick();
    ex_valid = 1'b0;
    @(negedge clk);
    total++;
    assert (mem_payload.branch_taken === 1'b0) else begin
      bad++; $error("FAIL br_bne got=%b exp=0", mem_payload.branch_taken);
    end
    tick();
    put(32'h7, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h8); tick();
    ex_valid = 1'b0;
    @(negedge clk);
    total++;
    assert (mem_payload.branch_target === 32'h4 && mem_payload.branch_taken === 1'b1) else begin
      bad++; $error("FAIL br_wrap got=%h exp=4", mem_payload.branch_target);
    end
    tick();

    // Flush with both slots full and an incoming beat.
    mem_ready = 1'b0;
    put(32'h111, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    put(32'h222, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    put(32'h333, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    flush = 1'b1; tick();
    flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    total++;
    assert (mem_valid === 1'b0 && ex_ready === 1'b1) else begin
      bad++; $error("FAIL flush_full got=%b%b exp=01", mem_valid, ex_ready);
    end
    tick();
    // Flush with only out full while a beat would be accepted.
    put(32'h444, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    put(32'h555, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    flush = 1'b1; tick();
    flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    total++;
    assert (mem_valid === 1'b0 && ex_ready === 1'b1) else begin
      bad++; $error("FAIL flush_in got=%b%b exp=01", mem_valid, ex_ready);
    end
    tick(); tick();

    // Reset mid-stream with both slots full.
    mem_ready = 1'b0;
    put(32'h666, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    put(32'h777, 1'b1, 1'b1, 1'b0, 32'h10, 32'h20); tick();
    ex_valid = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    assert (mem_valid === 1'b0 && ex_ready === 1'b1 && mem_payload === '0) else begin
      bad++; $error("FAIL rst_mid got=%b%b/%h exp=01/0", mem_valid, ex_ready, mem_payload);
    end
    tick();

    // Random traffic with random back-pressure and occasional flush.
    for (int i = 0; i < 200; i++) begin
      put($urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      ex_valid  = 1'($urandom_range(0, 3) != 0);
      mem_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    total++;
    assert (mem_valid === 1'b0 && sb.size() == 0) else begin
      bad++; $error("FAIL drain got=%b/%0d exp=0/0", mem_valid, sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline stage register with a two-entry skid buffer, sitting directly downstream of the ALU. Captures the ALU result and zero flag together with the instruction's memory/writeback control, resolves conditional branches from the zero flag, and hands the bundle to the memory stage over a valid/ready handshake. Provides full-throughput back-pressure isolation and a synchronous flush for branch mispredictions.

## Interface
- `DATA_WIDTH`, default `RISC_V_DATA_WIDTH` (32): width of result, store data, PC, immediate.
- `REG_ADDR_WIDTH`, default 5: destination register index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  discard all held and incoming entries this cycle.
- `ex_valid`  in  1  upstream entry valid.
- `ex_ready`  out  1  stage can accept; equals `!skid_valid`.
- `alu_result`  in  DATA_WIDTH  ALU `data_out`.
- `alu_zero`  in  1  ALU `zero`.
- `rs2_data`  in  DATA_WIDTH  store data.
- `pc`  in  DATA_WIDTH  instruction address.
- `imm`  in  DATA_WIDTH  sign-extended branch offset.
- `rd_addr`  in  REG_ADDR_WIDTH  destination register.
- `ctrl`  in  `ex_ctrl_t`  {reg_write, mem_read, mem_write, branch, branch_ne}.
- `mem_valid`  out  1  output entry valid.
- `mem_ready`  in  1  downstream accepts.
- `mem_payload`  out  `ex_mem_payload_t`  {alu_result, rs2_data, rd_addr, reg_write, mem_read, mem_write, branch_taken, branch_target}.

## Operation
- Two storage slots: `out` (drives `mem_*`) and `skid`. Each holds valid bit plus payload.
- In-transfer: `ex_valid && ex_ready`. Out-transfer: `mem_valid && mem_ready`.
- Payload formed at capture: `branch_taken = branch & (alu_zero ^ branch_ne)`; `branch_target = pc + imm`, modulo 2^DATA_WIDTH (wrap, no overflow flag). Non-branch entries carry `branch_taken = 0`, target still computed.
- `out` empty or out-transfer this cycle: `out` loads `skid` if `skid_valid`, else the in-transfer entry if any, else becomes invalid. If loaded from `skid` and an in-transfer also occurs, the new entry goes to `skid` (skid stays valid).
- `out` valid and no out-transfer: an in-transfer goes to `skid`; `skid_valid` set, `ex_ready` drops next cycle.
- `skid` can never be overwritten while valid (`ex_ready` = 0 guarantees it).
- Order preserved: entries leave in acceptance order.
- `flush`: next edge `out_valid = skid_valid = 0`; any in-transfer that cycle is discarded; an out-transfer that cycle still counts as delivered. Flush has priority over everything except `rst`.
- Payload of invalid slots is don't-care but must not change `mem_payload` while `mem_valid` is high and `mem_ready` low (stable-hold rule).

## Timing
- Reset: `mem_valid = 0`, `skid_valid = 0`, `ex_ready = 1` from the first cycle after reset, all payload fields 0. Handshakes in a cycle with `rst` high are ignored.
- Latency: entry accepted at edge N appears on `mem_*` after edge N (valid in cycle N+1) when `out` is free.
- Throughput: one entry per cycle sustained while `mem_ready` = 1.
- `ex_ready` is a register output (no combinational path from `mem_ready`); `mem_valid`/`mem_payload` are register outputs.
- Back-pressure: after `mem_ready` falls, at most one more entry is accepted (into `skid`).
- Reset mid-operation: both slots cleared, in-flight entries lost; no partial state retained.

## Structure
- `common_pkg`: add `ex_ctrl_t` and `ex_mem_payload_t` packed structs; reuse `RISC_V_DATA_WIDTH`. Add `REG_ADDR_WIDTH` constant (5).
- No sub-module; payload formation is a small combinational block, slots are two `always_ff` registers plus a valid-control block.

## Test plan
- Pass-through: `mem_ready` = 1, feed `alu_result` 0x10, 0x20, 0x30 back-to-back -> same values on `mem_payload` in cycles N+1..N+3, `ex_ready` always 1.
- Stall: `mem_ready` = 0, feed 0xA, 0xB, 0xC -> 0xA held on output, 0xB in skid, `ex_ready` = 0, 0xC not accepted; release `mem_ready` -> 0xA, 0xB, 0xC delivered in order, no loss or duplication.
- Branch: `ctrl.branch` = 1, `branch_ne` = 0, `alu_zero` = 1, `pc` = 0x100, `imm` = 0xFFFFFFF8 -> `branch_taken` = 1, `branch_target` = 0xF8; same with `branch_ne` = 1 -> `branch_taken` = 0.
- Wrap: `pc` = 0xFFFFFFFC, `imm` = 8 -> `branch_target` = 0x4.
- Flush: both slots full, assert `flush` with `ex_valid` = 1 -> next cycle `mem_valid` = 0, `ex_ready` = 1, flushed and incoming entries never appear.
- Reset mid-stream: `rst` pulsed with both slots full -> next cycle `mem_valid` = 0, payload 0, `ex_ready` = 1.
